// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load/link-use hazard control for the 5-stage pipeline.
// Optional stall counter output enabled by defining FWD_STALL_CNT_EN.
module fwd_hazard_ctrl #(
   parameter int unsigned REG_AW      = 5,
   parameter int unsigned NUM_FWD_SRC = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic [1:0]        id_datatoreg,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              stall,
   output logic              bubble
`ifdef FWD_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   localparam int unsigned SelW = $clog2(NUM_FWD_SRC);
   localparam logic [SelW-1:0] SelRf  = SelW'(0);
   localparam logic [SelW-1:0] SelMem = SelW'(1);
   localparam logic [SelW-1:0] SelWb  = SelW'(2);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic [1:0]        datatoreg;
   } wr_tag_t;

   typedef struct packed {
      wr_tag_t           wr;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic              uses_rs;
      logic              uses_rt;
   } ex_tag_t;

   ex_tag_t ex_q, ex_d;
   wr_tag_t mem_q, mem_d;
   wr_tag_t wb_q, wb_d;

   logic [SelW-1:0] sel_a, sel_b;
   logic            hazard;

   function automatic logic is_writer(wr_tag_t t);
      return t.valid & t.regwrite & (t.rd != '0);
   endfunction

   // MEM only forwards ALU results; loads/links are resolved via the stall.
   function automatic logic [SelW-1:0] fwd_sel(logic uses, logic [REG_AW-1:0] src,
                                                wr_tag_t mem, wr_tag_t wb);
      if (uses && is_writer(mem) && mem.datatoreg == 2'b00 && mem.rd == src) begin
         return SelMem;
      end else if (uses && is_writer(wb) && wb.rd == src) begin
         return SelWb;
      end
      return SelRf;
   endfunction

   always_comb begin
      sel_a = fwd_sel(ex_q.uses_rs, ex_q.rs, mem_q, wb_q);
      sel_b = fwd_sel(ex_q.uses_rt, ex_q.rt, mem_q, wb_q);
   end

   assign fwd_a_sel = sel_a;
   assign fwd_b_sel = sel_b;

   always_comb begin
      hazard = id_valid & ~flush & is_writer(ex_q.wr) & (ex_q.wr.datatoreg != 2'b00) &
               ((id_uses_rs & (id_rs == ex_q.wr.rd)) | (id_uses_rt & (id_rt == ex_q.wr.rd)));
      stall  = hazard & ~hold;
      bubble = (hazard | flush) & ~hold;
   end

   always_comb begin
      mem_d = ex_q.wr;
      wb_d  = mem_q;
      ex_d  = '0;
      if (!(stall || flush || !id_valid)) begin
         ex_d.wr.valid     = 1'b1;
         ex_d.wr.rd        = id_rd;
         ex_d.wr.regwrite  = id_regwrite;
         ex_d.wr.datatoreg = id_datatoreg;
         ex_d.rs           = id_rs;
         ex_d.rt           = id_rt;
         ex_d.uses_rs      = id_uses_rs;
         ex_d.uses_rt      = id_uses_rt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else if (!hold) begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   // WB writeback source is already resolved by the datapath mux.
   logic unused_wb_dtr;
   assign unused_wb_dtr = ^wb_q.datatoreg;

`ifdef FWD_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl; also checks stall_cnt when FWD_STALL_CNT_EN is defined.
module tb_fwd_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst, hold, flush, id_valid;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       id_uses_rs, id_uses_rt, id_regwrite;
   logic [1:0] id_datatoreg;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   logic       stall, bubble;
`ifdef FWD_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int errors = 0;
   int checks = 0;

   fwd_hazard_ctrl #(.REG_AW(5), .NUM_FWD_SRC(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .hold         (hold),
      .flush        (flush),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rs   (id_uses_rs),
      .id_uses_rt   (id_uses_rt),
      .id_rd        (id_rd),
      .id_regwrite  (id_regwrite),
      .id_datatoreg (id_datatoreg),
      .fwd_a_sel    (fwd_a_sel),
      .fwd_b_sel    (fwd_b_sel),
      .stall        (stall),
      .bubble       (bubble)
`ifdef FWD_STALL_CNT_EN
      ,
      .stall_cnt    (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic [4:0] rd, input logic rw,
                         input logic [1:0] dtr);
      id_valid = 1'b1;
      id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
      id_rd = rd; id_regwrite = rw; id_datatoreg = dtr;
   endtask

   task automatic set_nop();
      id_valid = 1'b0;
      id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
      id_rd = '0; id_regwrite = 1'b0; id_datatoreg = 2'b00;
   endtask

   task automatic drain();
      set_nop();
      repeat (3) tick();
   endtask

   task automatic chk(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                      input logic es, input logic eb_bub);
      #1;
      checks++;
      assert (fwd_a_sel === ea) else begin
         errors++;
         $error("FAIL %s fwd_a_sel got %0d expected %0d", tag, fwd_a_sel, ea);
      end
      checks++;
      assert (fwd_b_sel === eb) else begin
         errors++;
         $error("FAIL %s fwd_b_sel got %0d expected %0d", tag, fwd_b_sel, eb);
      end
      checks++;
      assert (stall === es) else begin
         errors++;
         $error("FAIL %s stall got %0d expected %0d", tag, stall, es);
      end
      checks++;
      assert (bubble === eb_bub) else begin
         errors++;
         $error("FAIL %s bubble got %0d expected %0d", tag, bubble, eb_bub);
      end
   endtask

   task automatic chk_cnt(input string tag, input int exp);
`ifdef FWD_STALL_CNT_EN
      checks++;
      assert (stall_cnt === 32'(exp)) else begin
         errors++;
         $error("FAIL %s stall_cnt got %0d expected %0d", tag, stall_cnt, exp);
      end
`else
      if (exp < 0) $display("unused %s", tag);
`endif
   endtask

   initial begin
      rst = 1'b1; hold = 1'b0; flush = 1'b0;
      set_nop();
      tick();
      rst = 1'b0;
      chk("reset", 2'b00, 2'b00, 1'b0, 1'b0);
      chk_cnt("reset_cnt", 0);

      // 1: add $3,$1,$2 ; sub $5,$3,$4
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 2'b00);
      chk("t1_add_id", 2'b00, 2'b00, 1'b0, 1'b0);
      tick();
      set_id(5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 2'b00);
      chk("t1_sub_id", 2'b00, 2'b00, 1'b0, 1'b0);
      tick();
      set_nop();
      chk("t1_sub_ex", 2'b01, 2'b00, 1'b0, 1'b0);
      drain();

      // 2: add $3 ; and $10,$11,$12 ; or $6,$3,$3
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 2'b00);
      tick();
      set_id(5'd11, 5'd12, 1'b1, 1'b1, 5'd10, 1'b1, 2'b00);
      tick();
      set_id(5'd3, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 2'b00);
      tick();
      set_nop();
      chk("t2_or_ex", 2'b10, 2'b10, 1'b0, 1'b0);
      drain();

      // 3: lw $8,0($1) ; add $9,$8,$1
      set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 2'b01);
      chk("t3_lw_id", 2'b00, 2'b00, 1'b0, 1'b0);
      tick();
      set_id(5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 2'b00);
      chk("t3_stall", 2'b00, 2'b00, 1'b1, 1'b1);
      chk_cnt("t3_cnt0", 0);
      tick();
      chk("t3_released", 2'b00, 2'b00, 1'b0, 1'b0);
      chk_cnt("t3_cnt1", 1);
      tick();
      set_nop();
      chk("t3_add_ex", 2'b10, 2'b00, 1'b0, 1'b0);
      drain();

      // 4a: writes to $0 never forward or stall
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 2'b00);
      tick();
      set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 2'b01);
      chk("t4_lw0_id", 2'b00, 2'b00, 1'b0, 1'b0);
      tick();
      set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 2'b00);
      chk("t4_rd0_id", 2'b00, 2'b00, 1'b0, 1'b0);
      tick();
      set_nop();
      chk("t4_rd0_ex", 2'b00, 2'b00, 1'b0, 1'b0);
      drain();

      // 4b: add $7 ; add $7 ; sub $8,$7,$5 -> MEM wins
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 2'b00);
      tick();
      set_id(5'd3, 5'd4, 1'b1, 1'b1, 5'd7, 1'b1, 2'b00);
      tick();
      set_id(5'd7, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 2'b00);
      chk("t4_sub_id", 2'b00, 2'b00, 1'b0, 1'b0);
      tick();
      set_nop();
      chk("t4_mem_wins", 2'b01, 2'b00, 1'b0, 1'b0);
      drain();

      // 5a: hold over a load-use hazard
      set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 2'b01);
      tick();
      set_id(5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 2'b00);
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("t5_hold", 2'b00, 2'b00, 1'b0, 1'b0);
         tick();
      end
      hold = 1'b0;
      chk("t5_hold_rel", 2'b00, 2'b00, 1'b1, 1'b1);
      chk_cnt("t5_cnt_hold", 1);
      tick();
      chk("t5_after", 2'b00, 2'b00, 1'b0, 1'b0);
      chk_cnt("t5_cnt2", 2);
      tick();
      set_nop();
      chk("t5_add_ex", 2'b10, 2'b00, 1'b0, 1'b0);
      drain();

      // 5b: flush in the hazard cycle
      set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 2'b01);
      tick();
      set_id(5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 2'b00);
      flush = 1'b1;
      chk("t5_flush", 2'b00, 2'b00, 1'b0, 1'b1);
      tick();
      flush = 1'b0;
      set_nop();
      chk("t5_flush_n1", 2'b00, 2'b00, 1'b0, 1'b0);
      tick();
      chk("t5_flush_n2", 2'b00, 2'b00, 1'b0, 1'b0);
      chk_cnt("t5_cnt_flush", 2);
      drain();

      // 5c: reset in the hazard cycle
      set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 2'b01);
      tick();
      set_id(5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 2'b00);
      chk("t5_pre_rst", 2'b00, 2'b00, 1'b1, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_post_rst", 2'b00, 2'b00, 1'b0, 1'b0);
      chk_cnt("t5_cnt_rst", 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
